axis_pool_stream: RTL
=====================

Name: axis_pool_stream

Overview:
- Parametrised successor to the fixed maxpool AXI-stream stage. Reduces K consecutive stream beats per lane into one output beat, using either signed max or shifted-sum average.
- Runtime window size, partial-window flush on tlast, and parametrised zero-lane edge padding on the output.
- Sits between the conv-engine output stream and the DMA/output packer.

Parameters:
- LANES, 16, data lanes per beat (groups*units*copies, flattened).
- WORD_WIDTH, 8, signed word width per lane.
- K_MAX, 4, maximum window length in beats (>=1).
- PAD, 1, zero lanes added on each side of the output.
- ZERO, 0, value driven on padded lanes.

Ports:
- aclk  in  1  clock
- aresetn  in  1  async active-low reset
- cfg_k  in  $clog2(K_MAX+1)  window length; sampled at the first beat of each packet
- cfg_mode  in  1  0=max, 1=average; sampled with cfg_k
- cfg_shift  in  $clog2(WORD_WIDTH+$clog2(K_MAX)+1)  right-shift for average; sampled with cfg_k
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tdata  in  LANES*WORD_WIDTH  lane l at bits [(l+1)*W-1 : l*W]
- s_axis_tkeep  in  LANES  per-lane keep
- s_axis_tlast  in  1  end of packet
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tdata  out  (LANES+2*PAD)*WORD_WIDTH  padded output
- m_axis_tkeep  out  LANES+2*PAD  padded keep
- m_axis_tlast  out  1  end of packet

Behaviour:
- Reset (async assert, sync-deasserted use): m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, cnt=0, state=IDLE, accumulators=0, latched cfg=k1/max/shift0.
- s_axis_tready = !m_axis_tvalid || m_axis_tready, with no dependence on s_axis_tvalid.
- Handshake = s_axis_tvalid && s_axis_tready.
- States:
  - IDLE: on handshake, latch cfg (cfg_k=0 treated as 1; cfg_k>K_MAX clamped to K_MAX) and go to ACCUM. If that beat closes a window with tlast, return to IDLE.
  - ACCUM: stays until a tlast handshake, then goes to IDLE.
- Per handshake: if cnt==0, acc[l]=sext(data[l]) and keep_acc=tkeep; else acc[l]=max(acc,data) (signed) or acc+data, and keep_acc&=tkeep.
- Accumulator width is WORD_WIDTH+$clog2(K_MAX); no overflow is possible.
- A window closes when cnt==k-1 or tlast=1. On close: cnt=0 and the output register loads; otherwise cnt++.
- Output value:
  - max mode: acc[l] truncated to WORD_WIDTH (exact).
  - avg mode: acc[l]>>>shift, saturated to the signed WORD_WIDTH range.
- A partial window at tlast emits over only the beats present; avg mode still uses the latched shift.
- Latency: output valid on the cycle after the closing handshake. Full throughput is 1 output per k input beats with no bubbles, including back-to-back packets.
- m_axis_tvalid clears on m_axis_tready when no new close occurs that cycle. A simultaneous drain and close reloads the register and keeps valid=1.
- Output data and keep hold stable while valid && !ready.
- Padding:
  - Output lanes [0, PAD) and [LANES+PAD, LANES+2*PAD) carry ZERO, with keep = keep of data lane 0.
  - Data lane l maps to output lane l+PAD.
- m_axis_tlast = tlast of the closing beat.
- cfg_* changes mid-packet are ignored until the next IDLE.
- Reset mid-packet discards the partial window and any pending output.

Test Plan:
- Max, k=2, LANES=16, lane0 beats {3,-5} then {7,2}, tlast on beat 2 -> one output: lane0(out1)=7, out0=out17=0, tlast=1, 1 cycle after the last handshake.
- Avg, k=4, shift=2, lane0 beats 10,20,30,41 -> out 25. Beats 127,127,127,127 with shift=0 -> saturates to 127. Beats -128 x4 with shift=0 -> saturates to -128.
- k=3, packet of 7 beats -> outputs after beats 3, 6, 7. The third output is the max over beat 7 only, with tlast=1.
- Backpressure: hold m_axis_tready=0 with output valid -> s_axis_tready=0 and tdata stable. Release -> 1 output/k beats with no drop; random tready over 1000 beats matches the reference model.
- Keep: lane 5 keep=0 on 1 of 2 window beats -> out keep[6]=0. Lane0 keep=1 -> pad keeps=1.
- cfg_k=0 -> behaves as k=1 (passthrough plus padding). Assert aresetn mid-window -> all outputs 0 immediately; the next packet starts with cnt=0.

Source files
------------

// File: rtl/axis_pool_stream.sv
// AXI-stream pooling stage: reduces K beats per lane to one output beat (signed max or
// shifted-sum average), with partial-window flush on tlast and zero-lane edge padding.
module axis_pool_stream #(
  parameter int unsigned LANES      = 16,
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned K_MAX      = 4,
  parameter int unsigned PAD        = 1,
  parameter int          ZERO       = 0
) (
  input  logic                                        aclk,
  input  logic                                        aresetn,
  input  logic [$clog2(K_MAX+1)-1:0]                  cfg_k,
  input  logic                                        cfg_mode,
  input  logic [$clog2(WORD_WIDTH+$clog2(K_MAX)+1)-1:0] cfg_shift,
  input  logic                                        s_axis_tvalid,
  output logic                                        s_axis_tready,
  input  logic [LANES*WORD_WIDTH-1:0]                 s_axis_tdata,
  input  logic [LANES-1:0]                            s_axis_tkeep,
  input  logic                                        s_axis_tlast,
  output logic                                        m_axis_tvalid,
  input  logic                                        m_axis_tready,
  output logic [(LANES+2*PAD)*WORD_WIDTH-1:0]         m_axis_tdata,
  output logic [LANES+2*PAD-1:0]                      m_axis_tkeep,
  output logic                                        m_axis_tlast
);

  localparam int unsigned KW = $clog2(K_MAX + 1);
  localparam int unsigned SW = $clog2(WORD_WIDTH + $clog2(K_MAX) + 1);
  localparam int unsigned AW = WORD_WIDTH + $clog2(K_MAX);
  localparam int unsigned OL = LANES + 2 * PAD;

  localparam logic [WORD_WIDTH-1:0] ZeroW  = WORD_WIDTH'(ZERO);
  localparam logic signed [AW-1:0]  SatMax = AW'(2 ** (WORD_WIDTH - 1) - 1);
  localparam logic signed [AW-1:0]  SatMin = ~SatMax;

  typedef enum logic [0:0] {StIdle, StAccum} state_t;

  state_t                  state_q, state_d;
  logic [KW-1:0]           k_q, k_in, k_eff;
  logic                    mode_q, mode_eff;
  logic [SW-1:0]           shift_q, shift_eff;
  logic [KW-1:0]           cnt_q, cnt_d;
  logic signed [AW-1:0]    acc_q   [LANES];
  logic signed [AW-1:0]    acc_nxt [LANES];
  logic signed [AW-1:0]    din     [LANES];
  logic signed [AW-1:0]    sh      [LANES];
  logic [WORD_WIDTH-1:0]   res     [LANES];
  logic [LANES-1:0]        keep_q, keep_acc_nxt;

  logic                    tvalid_q, tlast_q;
  logic [OL*WORD_WIDTH-1:0] tdata_q, data_nxt;
  logic [OL-1:0]           tkeep_q, keep_nxt;

  logic                    hs, close;

  assign s_axis_tready = !tvalid_q || m_axis_tready;
  assign hs            = s_axis_tvalid && s_axis_tready;

  always_comb begin
    if (cfg_k == '0) begin
      k_in = KW'(1);
    end else if (cfg_k > KW'(K_MAX)) begin
      k_in = KW'(K_MAX);
    end else begin
      k_in = cfg_k;
    end
  end

  // The first beat of a packet uses the live cfg; later beats use the latched copy.
  assign k_eff     = (state_q == StIdle) ? k_in      : k_q;
  assign mode_eff  = (state_q == StIdle) ? cfg_mode  : mode_q;
  assign shift_eff = (state_q == StIdle) ? cfg_shift : shift_q;

  assign close = hs && ((cnt_q == k_eff - KW'(1)) || s_axis_tlast);

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      din[l] = AW'($signed(s_axis_tdata[l*WORD_WIDTH +: WORD_WIDTH]));
      if (cnt_q == '0) begin
        acc_nxt[l] = din[l];
      end else if (mode_eff) begin
        acc_nxt[l] = acc_q[l] + din[l];
      end else begin
        acc_nxt[l] = (din[l] > acc_q[l]) ? din[l] : acc_q[l];
      end
      sh[l] = acc_nxt[l] >>> shift_eff;
      if (!mode_eff) begin
        res[l] = acc_nxt[l][WORD_WIDTH-1:0];
      end else if (sh[l] > SatMax) begin
        res[l] = SatMax[WORD_WIDTH-1:0];
      end else if (sh[l] < SatMin) begin
        res[l] = SatMin[WORD_WIDTH-1:0];
      end else begin
        res[l] = sh[l][WORD_WIDTH-1:0];
      end
    end
  end

  assign keep_acc_nxt = (cnt_q == '0) ? s_axis_tkeep : (keep_q & s_axis_tkeep);

  // Pad lanes carry ZERO and mirror the keep of data lane 0.
  always_comb begin
    data_nxt = {OL{ZeroW}};
    for (int l = 0; l < LANES; l++) begin
      data_nxt[(l+PAD)*WORD_WIDTH +: WORD_WIDTH] = res[l];
    end
    keep_nxt = {OL{keep_acc_nxt[0]}};
    keep_nxt[PAD +: LANES] = keep_acc_nxt;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (hs) begin
          state_d = (close && s_axis_tlast) ? StIdle : StAccum;
        end
      end
      StAccum: begin
        if (hs && s_axis_tlast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hs) begin
      cnt_d = close ? '0 : cnt_q + KW'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      k_q     <= KW'(1);
      mode_q  <= 1'b0;
      shift_q <= '0;
      keep_q  <= '0;
      for (int l = 0; l < LANES; l++) begin
        acc_q[l] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hs) begin
        keep_q <= keep_acc_nxt;
        for (int l = 0; l < LANES; l++) begin
          acc_q[l] <= acc_nxt[l];
        end
        if (state_q == StIdle) begin
          k_q     <= k_in;
          mode_q  <= cfg_mode;
          shift_q <= cfg_shift;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
    end else if (close) begin
      tvalid_q <= 1'b1;
      tlast_q  <= s_axis_tlast;
      tdata_q  <= data_nxt;
      tkeep_q  <= keep_nxt;
    end else if (m_axis_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;

endmodule
